key_event_conditioner: RTL and testbench
========================================

// Module: key_event_conditioner
// PURPOSE
// - Input-side front end for the egg-timer pushbuttons: takes the raw, bouncing,
//   asynchronous active-low KEY lines and produces clean events for the control
//   path. Events are debounced press levels, one-cycle press/release pulses and
//   gated toggle bits (the set/run request toggles the StateMachine consumes).
// - Sits between the board KEY pins and the StateMachine. It replaces ad-hoc
//   inversion plus toggle flops with one synchronised, debounced block.
// PARAMETERS
// - NUM_KEYS         3       number of key channels handled
// - DEBOUNCE_CYCLES  500000  cycles an input must be stable before it is accepted
//                            (10 ms at 50 MHz); legal range >= 2
// - CNT_W            19      debounce counter width; must satisfy
//                            2**CNT_W > DEBOUNCE_CYCLES
// PORTS
// - clk            in   1         CLOCK_50 domain clock, rising edge
// - reset_n        in   1         asynchronous active-low reset
// - key_n          in   NUM_KEYS  raw KEY pins, active-low (0 = pressed), asynchronous
// - toggle_enable  in   NUM_KEYS  per key: 1 = a press flips toggle[i] (gating,
//                                 e.g. run only valid in minute/running states)
// - toggle_clear   in   1         synchronous clear of all toggle bits
// - pressed        out  NUM_KEYS  debounced level, active-high (1 = held)
// - press_pulse    out  NUM_KEYS  1-cycle pulse on accepted press
// - release_pulse  out  NUM_KEYS  1-cycle pulse on accepted release
// - toggle         out  NUM_KEYS  toggle state, flipped by enabled presses
// BEHAVIOUR
// - Reset (reset_n=0, async): sync flops = 1 (released), counters = 0,
//   pressed = 0, press_pulse = 0, release_pulse = 0, toggle = 0.
// - Sync: key_n[i] passes through a 2-flop synchroniser -> s[i]. raw_i = ~s[i].
// - Debounce, per channel:
//   - raw_i == pressed[i]: counter cleared to 0.
//   - otherwise the counter increments each cycle.
//   - In the cycle the counter equals DEBOUNCE_CYCLES-1 while raw_i still differs,
//     pressed[i] <= raw_i and the counter is cleared.
//   - Any glitch shorter than DEBOUNCE_CYCLES restarts the count; the counter
//     never wraps.
// - Latency: a clean edge on key_n reaches pressed 2 + DEBOUNCE_CYCLES cycles
//   later. press_pulse/release_pulse are asserted in the same cycle pressed
//   changes, for exactly 1 cycle.
// - Toggle, per channel, registered; priority: toggle_clear > press.
//   - toggle_clear=1: toggle <= 0, even if a press_pulse occurs that cycle.
//   - else press_pulse[i] & toggle_enable[i]: toggle[i] <= ~toggle[i].
//   - toggle_enable is sampled in the press_pulse cycle only. A press while it is
//     disabled is dropped, not deferred.
// - Channels are independent; simultaneous events on several keys are all honoured.
// - Reset mid-count: the count is discarded. After release of reset_n a held key
//   is re-accepted only after the full 2 + DEBOUNCE_CYCLES delay (no spurious
//   pulse during reset).
// - Held key: exactly one press_pulse; no auto-repeat.
// STRUCTURE
// - Shared package (timer_pkg): KEY_RESET=0, KEY_SET=1, KEY_RUN=2 index constants;
//   DEBOUNCE_CYCLES_DEFAULT and its sim override value 4.
// - One sub-module: key_debounce_channel, which holds the synchroniser, counter,
//   pressed level and pulses for one key. It is instantiated NUM_KEYS times in a
//   generate loop.
// - Toggle logic and clear priority stay in the top of this block.
// TESTING (sim with DEBOUNCE_CYCLES=4)
// - Reset: hold reset_n=0 with key_n=3'b000 -> all outputs 0. Release reset_n
//   -> pressed=3'b111 exactly 6 cycles later, one press_pulse per key.
// - Clean press: key_n[1] 1->0 held 10 cycles -> press_pulse[1] high 1 cycle
//   at +6. Releasing it -> release_pulse[1] at +6 after the release.
// - Bounce: key_n[2] low 3 cycles, high 1, low 3, high -> no pulse, pressed[2]
//   stays 0. Then low 5 cycles -> accepted.
// - Gating: toggle_enable[2]=0 and press key 2 -> toggle[2] stays 0. Set enable=1
//   and press -> toggle[2]=1. Press again -> 0.
// - Clear priority: toggle_clear=1 in the same cycle as press_pulse[1] with
//   toggle[1]=1 -> toggle[1]=0 next cycle, not 1.
// - Simultaneous: press keys 0 and 1 on the same cycle, both enabled -> both
//   pulses together, both toggles flip. Assert reset_n low mid-count -> no pulse.

Source files
------------

// File: rtl/timer_pkg.sv
// ---------------------------------------------------------------------------
// timer_pkg
// Shared constants for the egg-timer control path.
//   KEY_RESET / KEY_SET / KEY_RUN : index of each pushbutton in the key vectors
//   DEBOUNCE_CYCLES_DEFAULT       : 10 ms debounce window at 50 MHz
//   DEBOUNCE_CYCLES_SIM           : short window used in simulation
// ---------------------------------------------------------------------------
package timer_pkg;

   localparam int KEY_RESET = 0;
   localparam int KEY_SET   = 1;
   localparam int KEY_RUN   = 2;

   localparam int DEBOUNCE_CYCLES_DEFAULT = 500000;
   localparam int DEBOUNCE_CYCLES_SIM     = 4;

endpackage : timer_pkg

// File: rtl/key_debounce_channel.sv
// ---------------------------------------------------------------------------
// key_debounce_channel
// One pushbutton: 2-flop synchroniser, stability counter, debounced level and
// one-cycle press/release pulses.
//   clk           : clock, rising edge
//   reset_n       : asynchronous active-low reset
//   key_n         : raw asynchronous key pin, active-low
//   pressed       : debounced level, 1 = held
//   press_pulse   : 1-cycle pulse when a press is accepted
//   release_pulse : 1-cycle pulse when a release is accepted
// ---------------------------------------------------------------------------
module key_debounce_channel #(
   parameter int DEBOUNCE_CYCLES = 500000,
   parameter int CNT_W           = 19
) (
   input  logic clk,
   input  logic reset_n,
   input  logic key_n,
   output logic pressed,
   output logic press_pulse,
   output logic release_pulse
);

   logic             sync1_q, sync1_d;
   logic             sync2_q, sync2_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             pressed_q, pressed_d;
   logic             press_pulse_q, press_pulse_d;
   logic             release_pulse_q, release_pulse_d;
   logic             raw;

   assign raw = ~sync2_q;

   // NOTE: every always_comb output gets a default first so no path leaves it
   // unassigned; a missing default would infer a latch.
   always_comb begin
      sync1_d         = key_n;
      sync2_d         = sync1_q;
      cnt_d           = '0;
      pressed_d       = pressed_q;
      press_pulse_d   = 1'b0;
      release_pulse_d = 1'b0;

      // Counter only runs while the synchronised level disagrees with the
      // accepted level; any agreeing cycle restarts it. It is cleared on
      // acceptance, so it tops out at DEBOUNCE_CYCLES-1 and never wraps.
      if (raw != pressed_q) begin
         if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
            pressed_d       = raw;
            press_pulse_d   = raw;
            release_pulse_d = ~raw;
         end else begin
            cnt_d = cnt_q + CNT_W'(1);
         end
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every flop
   // samples the pre-edge values, independent of statement order.
   // Synchroniser resets to 1 (released) so no spurious press follows reset.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sync1_q         <= 1'b1;
         sync2_q         <= 1'b1;
         cnt_q           <= '0;
         pressed_q       <= 1'b0;
         press_pulse_q   <= 1'b0;
         release_pulse_q <= 1'b0;
      end else begin
         sync1_q         <= sync1_d;
         sync2_q         <= sync2_d;
         cnt_q           <= cnt_d;
         pressed_q       <= pressed_d;
         press_pulse_q   <= press_pulse_d;
         release_pulse_q <= release_pulse_d;
      end
   end

   assign pressed       = pressed_q;
   assign press_pulse   = press_pulse_q;
   assign release_pulse = release_pulse_q;

endmodule : key_debounce_channel

// File: rtl/key_event_conditioner.sv
// ---------------------------------------------------------------------------
// key_event_conditioner
// Front end for the egg-timer pushbuttons: one debounce channel per key plus
// gated toggle bits consumed by the StateMachine.
//   clk           : CLOCK_50 domain clock, rising edge
//   reset_n       : asynchronous active-low reset
//   key_n         : raw KEY pins, active-low, asynchronous
//   toggle_enable : per key, 1 = an accepted press flips toggle[i]
//   toggle_clear  : synchronous clear of all toggle bits (wins over presses)
//   pressed       : debounced levels, active-high
//   press_pulse   : 1-cycle pulses on accepted presses
//   release_pulse : 1-cycle pulses on accepted releases
//   toggle        : toggle state per key
// ---------------------------------------------------------------------------
module key_event_conditioner
   import timer_pkg::*;
#(
   parameter int NUM_KEYS        = 3,
   parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
   parameter int CNT_W           = 19
) (
   input  logic                clk,
   input  logic                reset_n,
   input  logic [NUM_KEYS-1:0] key_n,
   input  logic [NUM_KEYS-1:0] toggle_enable,
   input  logic                toggle_clear,
   output logic [NUM_KEYS-1:0] pressed,
   output logic [NUM_KEYS-1:0] press_pulse,
   output logic [NUM_KEYS-1:0] release_pulse,
   output logic [NUM_KEYS-1:0] toggle
);

   logic [NUM_KEYS-1:0] toggle_q, toggle_d;

   for (genvar i = 0; i < NUM_KEYS; i++) begin : g_key
      key_debounce_channel #(
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
         .CNT_W           (CNT_W)
      ) u_chan (
         .clk           (clk),
         .reset_n       (reset_n),
         .key_n         (key_n[i]),
         .pressed       (pressed[i]),
         .press_pulse   (press_pulse[i]),
         .release_pulse (release_pulse[i])
      );
   end

   // Enable is only looked at in the pulse cycle: a press while disabled is
   // dropped. Clear overrides a coincident press.
   always_comb begin
      toggle_d = toggle_q;
      if (toggle_clear) begin
         toggle_d = '0;
      end else begin
         toggle_d = toggle_q ^ (press_pulse & toggle_enable);
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         toggle_q <= '0;
      end else begin
         toggle_q <= toggle_d;
      end
   end

   assign toggle = toggle_q;

endmodule : key_event_conditioner

// File: tb/tb_key_event_conditioner.sv
// ---------------------------------------------------------------------------
// tb_key_event_conditioner
// Directed and randomized stimulus for key_event_conditioner with a short
// debounce window. The reference model keeps a history of sampled key levels
// and accepts a new level once the last DEBOUNCE_CYCLES synchronised samples
// all disagree with the current accepted level.
// ---------------------------------------------------------------------------
module tb_key_event_conditioner;
   import timer_pkg::*;

   localparam int NK = 3;
   localparam int D  = DEBOUNCE_CYCLES_SIM;

   logic          clk = 1'b0;
   logic          reset_n = 1'b0;
   logic [NK-1:0] key_n = '1;
   logic [NK-1:0] toggle_enable = '0;
   logic          toggle_clear = 1'b0;
   logic [NK-1:0] pressed, press_pulse, release_pulse, toggle;

   key_event_conditioner #(
      .NUM_KEYS        (NK),
      .DEBOUNCE_CYCLES (D),
      .CNT_W           (3)
   ) dut (
      .clk           (clk),
      .reset_n       (reset_n),
      .key_n         (key_n),
      .toggle_enable (toggle_enable),
      .toggle_clear  (toggle_clear),
      .pressed       (pressed),
      .press_pulse   (press_pulse),
      .release_pulse (release_pulse),
      .toggle        (toggle)
   );

   always #5 clk = ~clk;

   int vectors = 0;
   int miscompares = 0;

   // Reference model state
   logic [NK-1:0] m_pressed, m_pp, m_rp, m_tog;
   logic [NK-1:0] hist[$];   // hist[0] = key_n sampled at the latest edge

   task automatic check(input string tag, input logic [NK-1:0] obs, input logic [NK-1:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   task automatic check_model(input string tag);
      check({tag, ".pressed"},       pressed,       m_pressed);
      check({tag, ".press_pulse"},   press_pulse,   m_pp);
      check({tag, ".release_pulse"}, release_pulse, m_rp);
      check({tag, ".toggle"},        toggle,        m_tog);
   endtask

   task automatic model_reset();
      m_pressed = '0;
      m_pp      = '0;
      m_rp      = '0;
      m_tog     = '0;
      hist.delete();
      repeat (D + 2) hist.push_back('1);
   endtask

   // One rising edge: advance the model with the inputs present at the edge,
   // then compare shortly after the edge.
   task automatic tick(input string tag);
      logic [NK-1:0] h;
      bit            all_differ;
      @(posedge clk);
      if (!reset_n) begin
         model_reset();
      end else begin
         // Toggle sees the pulses that were visible before this edge.
         if (toggle_clear) m_tog = '0;
         else              m_tog = m_tog ^ (m_pp & toggle_enable);
         hist.push_front(key_n);
         void'(hist.pop_back());
         m_pp = '0;
         m_rp = '0;
         for (int i = 0; i < NK; i++) begin
            all_differ = 1'b1;
            // Synchronised level seen at edge t-j is the pin sampled at t-j-2.
            for (int j = 0; j < D; j++) begin
               h = hist[j + 2];
               if (~h[i] == m_pressed[i]) all_differ = 1'b0;
            end
            if (all_differ) begin
               m_pressed[i] = ~m_pressed[i];
               if (m_pressed[i]) m_pp[i] = 1'b1;
               else              m_rp[i] = 1'b1;
            end
         end
      end
      #1;
      check_model(tag);
   endtask

   task automatic ticks(input int n, input string tag);
      for (int k = 0; k < n; k++) tick(tag);
   endtask

   task automatic assert_reset();
      reset_n = 1'b0;
      #1;
      model_reset();
      check_model("async_reset");
   endtask

   initial begin
      model_reset();

      // Reset with all keys held
      key_n = 3'b000;
      ticks(3, "in_reset");
      check("rst_pressed", pressed, 3'b000);
      reset_n = 1'b1;
      ticks(5, "rst_rel");
      check("rst_rel_p5", pressed, 3'b000);
      tick("rst_rel");
      check("rst_rel_p6_pressed", pressed, 3'b111);
      check("rst_rel_p6_pulse", press_pulse, 3'b111);
      key_n = 3'b111;
      ticks(10, "rel_all");

      // Clean press / release on key 1
      key_n = 3'b101;
      ticks(5, "clean_press");
      check("clean_press_p5", press_pulse, 3'b000);
      tick("clean_press");
      check("clean_press_p6", press_pulse, 3'b010);
      tick("clean_press");
      check("clean_press_p7", press_pulse, 3'b000);
      ticks(3, "clean_hold");
      key_n = 3'b111;
      ticks(5, "clean_rel");
      tick("clean_rel");
      check("clean_rel_p6", release_pulse, 3'b010);
      ticks(4, "clean_rel");

      // Bounce on key 2
      key_n = 3'b011; ticks(3, "bounce");
      key_n = 3'b111; ticks(1, "bounce");
      key_n = 3'b011; ticks(3, "bounce");
      key_n = 3'b111; ticks(10, "bounce");
      check("bounce_pressed", pressed, 3'b000);
      key_n = 3'b011; ticks(5, "bounce_acc");
      key_n = 3'b111; tick("bounce_acc");
      check("bounce_acc_pulse", press_pulse, 3'b100);
      ticks(10, "bounce_rel");

      // Gating on key 2
      toggle_enable = 3'b000;
      key_n = 3'b011; ticks(8, "gate_off");
      key_n = 3'b111; ticks(8, "gate_off");
      check("gate_off_toggle", toggle, 3'b000);
      toggle_enable = 3'b100;
      key_n = 3'b011; ticks(8, "gate_on");
      check("gate_on_toggle", toggle, 3'b100);
      key_n = 3'b111; ticks(8, "gate_on");
      key_n = 3'b011; ticks(8, "gate_again");
      check("gate_again_toggle", toggle, 3'b000);
      key_n = 3'b111; ticks(8, "gate_again");

      // Clear priority on key 1
      toggle_enable = 3'b010;
      key_n = 3'b101; ticks(8, "clr_setup");
      key_n = 3'b111; ticks(8, "clr_setup");
      check("clr_setup_toggle", toggle, 3'b010);
      key_n = 3'b101; ticks(6, "clr_press");
      check("clr_pulse", press_pulse, 3'b010);
      toggle_clear = 1'b1;
      tick("clr_edge");
      check("clr_wins", toggle, 3'b000);
      toggle_clear = 1'b0;
      key_n = 3'b111; ticks(8, "clr_rel");

      // Simultaneous presses on keys 0 and 1
      toggle_enable = 3'b011;
      key_n = 3'b100; ticks(6, "simul");
      check("simul_pulse", press_pulse, 3'b011);
      tick("simul");
      check("simul_toggle", toggle, 3'b011);
      key_n = 3'b111; ticks(8, "simul_rel");

      // Reset mid-count, key held through it
      key_n = 3'b110; ticks(3, "mid_count");
      assert_reset();
      ticks(2, "mid_in_reset");
      reset_n = 1'b1;
      ticks(5, "mid_rel");
      check("mid_rel_no_pulse", press_pulse, 3'b000);
      tick("mid_rel");
      check("mid_rel_p6", press_pulse, 3'b001);
      key_n = 3'b111; ticks(8, "mid_key_rel");

      // Randomized keys, enables and clears
      for (int c = 0; c < 600; c++) begin
         for (int i = 0; i < NK; i++)
            if ($urandom_range(0, 4) == 0) key_n[i] = ~key_n[i];
         toggle_enable = NK'($urandom);
         toggle_clear  = ($urandom_range(0, 15) == 0);
         tick("random");
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule : tb_key_event_conditioner
